// File: rtl/stats_dma_pkg.sv
// Shared helpers for the DMA latency collector: channel index width
// and the packed result record layout used by hold and output registers.
package stats_dma_pkg;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_COUNT_DEF = 2;
    localparam int CH_WIDTH_DEF = ch_width(CH_COUNT_DEF);

    // Record layout, LSB first: tag, len, status, latency, error.
    localparam int OFF_TAG = 0;

    function automatic int off_len(input int tw);
        return tw;
    endfunction

    function automatic int off_status(input int tw, input int lw);
        return tw + lw;
    endfunction

    function automatic int off_lat(input int tw, input int lw, input int sw);
        return tw + lw + sw;
    endfunction

    function automatic int off_err(input int tw, input int lw, input int sw,
                                   input int cw);
        return tw + lw + sw + cw;
    endfunction

    function automatic int rec_width(input int tw, input int lw, input int sw,
                                     input int cw);
        return tw + lw + sw + cw + 1;
    endfunction

endpackage

// File: rtl/stats_dma_latency_ch.sv
// One collector channel: tag memories, in-flight bitmap and a single
// holding register drained by the top-level arbiter.
module stats_dma_latency_ch
    import stats_dma_pkg::*;
#(
    parameter int COUNT_WIDTH  = 16,
    parameter int TAG_WIDTH    = 8,
    parameter int LEN_WIDTH    = 16,
    parameter int STATUS_WIDTH = 4,
    localparam int REC_WIDTH   = rec_width(TAG_WIDTH, LEN_WIDTH,
                                           STATUS_WIDTH, COUNT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COUNT_WIDTH-1:0]  count,
    input  logic [TAG_WIDTH-1:0]    start_tag,
    input  logic [LEN_WIDTH-1:0]    start_len,
    input  logic                    start_valid,
    input  logic [TAG_WIDTH-1:0]    finish_tag,
    input  logic [STATUS_WIDTH-1:0] finish_status,
    input  logic                    finish_valid,
    input  logic                    drain,
    output logic                    hold_valid,
    output logic [REC_WIDTH-1:0]    hold_rec,
    output logic                    drop
);

    localparam int DEPTH  = 2 ** TAG_WIDTH;
    localparam int O_LEN  = off_len(TAG_WIDTH);
    localparam int O_STAT = off_status(TAG_WIDTH, LEN_WIDTH);
    localparam int O_LAT  = off_lat(TAG_WIDTH, LEN_WIDTH, STATUS_WIDTH);
    localparam int O_ERR  = off_err(TAG_WIDTH, LEN_WIDTH, STATUS_WIDTH,
                                    COUNT_WIDTH);

    logic [LEN_WIDTH-1:0]   mem_len [DEPTH];
    logic [COUNT_WIDTH-1:0] mem_cnt [DEPTH];
    logic [DEPTH-1:0]       inflight;
    logic                   hit;
    logic                   accept;
    logic [REC_WIDTH-1:0]   rec;

    assign hit    = inflight[finish_tag];
    assign accept = finish_valid && (!hold_valid || drain);
    assign drop   = finish_valid && hold_valid && !drain;

    // Build the result record from the pre-edge memory contents.
    always_comb begin
        rec = '0;
        rec[OFF_TAG +: TAG_WIDTH]   = finish_tag;
        rec[O_STAT +: STATUS_WIDTH] = finish_status;
        rec[O_ERR]                  = !hit;
        if (hit) begin
            rec[O_LEN +: LEN_WIDTH]   = mem_len[finish_tag];
            rec[O_LAT +: COUNT_WIDTH] = count - mem_cnt[finish_tag];
        end
    end

    // Start writes length and timestamp; memories are not reset.
    always_ff @(posedge clk) begin
        if (start_valid) begin
            mem_len[start_tag] <= start_len;
            mem_cnt[start_tag] <= count;
        end
    end

    // Start is applied after finish so a same-tag start stays in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            if (finish_valid) inflight[finish_tag] <= 1'b0;
            if (start_valid)  inflight[start_tag]  <= 1'b1;
        end
    end

    // Holding register: refills in the cycle it is drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_rec   <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_rec   <= rec;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stats_dma_latency_mc.sv
// Multi-channel DMA latency collector: timebase, round-robin merge, output reg.
// Optional drop counter enabled by STATS_DMA_LATENCY_DROP_CNT_EN.
module stats_dma_latency_mc
    import stats_dma_pkg::*;
#(
    parameter int CH_COUNT     = CH_COUNT_DEF,
    parameter int COUNT_WIDTH  = 16,
    parameter int TAG_WIDTH    = 8,
    parameter int LEN_WIDTH    = 16,
    parameter int STATUS_WIDTH = 4,
    parameter int DROP_WIDTH   = 16,
    localparam int CH_WIDTH    = ch_width(CH_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CH_COUNT*TAG_WIDTH-1:0]    in_start_tag,
    input  logic [CH_COUNT*LEN_WIDTH-1:0]    in_start_len,
    input  logic [CH_COUNT-1:0]              in_start_valid,
    input  logic [CH_COUNT*TAG_WIDTH-1:0]    in_finish_tag,
    input  logic [CH_COUNT*STATUS_WIDTH-1:0] in_finish_status,
    input  logic [CH_COUNT-1:0]              in_finish_valid,
    output logic [CH_WIDTH-1:0]              out_ch,
    output logic [TAG_WIDTH-1:0]             out_tag,
    output logic [LEN_WIDTH-1:0]             out_len,
    output logic [STATUS_WIDTH-1:0]          out_status,
    output logic [COUNT_WIDTH-1:0]           out_latency,
    output logic                             out_error,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
    ,
    output logic [DROP_WIDTH-1:0]            drop_count
`endif
);

    localparam int REC_WIDTH = rec_width(TAG_WIDTH, LEN_WIDTH,
                                         STATUS_WIDTH, COUNT_WIDTH);
    localparam int O_LEN  = off_len(TAG_WIDTH);
    localparam int O_STAT = off_status(TAG_WIDTH, LEN_WIDTH);
    localparam int O_LAT  = off_lat(TAG_WIDTH, LEN_WIDTH, STATUS_WIDTH);
    localparam int O_ERR  = off_err(TAG_WIDTH, LEN_WIDTH, STATUS_WIDTH,
                                    COUNT_WIDTH);
    localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(CH_COUNT - 1);

    logic [COUNT_WIDTH-1:0] count_reg;
    logic [CH_COUNT-1:0]    hold_valid;
    logic [CH_COUNT-1:0]    drain;
    logic [REC_WIDTH-1:0]   hold_rec [CH_COUNT];
    logic [CH_WIDTH-1:0]    ptr;
    logic [CH_WIDTH-1:0]    win;
    logic [CH_WIDTH-1:0]    idx;
    logic                   found;
    logic                   load;
    logic [REC_WIDTH-1:0]   out_rec;
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
    logic [CH_COUNT-1:0]    drop;
    logic [DROP_WIDTH-1:0]  drop_next;
`endif

    for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
        stats_dma_latency_ch #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .TAG_WIDTH    (TAG_WIDTH),
            .LEN_WIDTH    (LEN_WIDTH),
            .STATUS_WIDTH (STATUS_WIDTH)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .count         (count_reg),
            .start_tag     (in_start_tag[g*TAG_WIDTH +: TAG_WIDTH]),
            .start_len     (in_start_len[g*LEN_WIDTH +: LEN_WIDTH]),
            .start_valid   (in_start_valid[g]),
            .finish_tag    (in_finish_tag[g*TAG_WIDTH +: TAG_WIDTH]),
            .finish_status (in_finish_status[g*STATUS_WIDTH +: STATUS_WIDTH]),
            .finish_valid  (in_finish_valid[g]),
            .drain         (drain[g]),
            .hold_valid    (hold_valid[g]),
            .hold_rec      (hold_rec[g]),
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
            .drop          (drop[g])
`else
            .drop          ()
`endif
        );
    end

    // Free-running shared timebase.
    always_ff @(posedge clk) begin
        if (rst) count_reg <= '0;
        else     count_reg <= count_reg + 1'b1;
    end

    // Round-robin search starting at the grant pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            idx = CH_WIDTH'((int'(ptr) + i) % CH_COUNT);
            if (!found && hold_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign load = !out_valid || out_ready;

    // Drain only the granted channel, only when the output register loads.
    always_comb begin
        drain = '0;
        if (load && found) drain[win] = 1'b1;
    end

    // Output register and grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rec   <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_rec <= hold_rec[win];
                out_ch  <= win;
                ptr     <= (win == LAST_CH) ? '0 : win + 1'b1;
            end
        end
    end

    assign out_tag     = out_rec[OFF_TAG +: TAG_WIDTH];
    assign out_len     = out_rec[O_LEN +: LEN_WIDTH];
    assign out_status  = out_rec[O_STAT +: STATUS_WIDTH];
    assign out_latency = out_rec[O_LAT +: COUNT_WIDTH];
    assign out_error   = out_rec[O_ERR];

`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
    // Add one per dropping channel, stopping at all-ones.
    always_comb begin
        drop_next = drop_count;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (drop[i] && (drop_next != '1)) drop_next = drop_next + 1'b1;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) drop_count <= '0;
        else     drop_count <= drop_next;
    end
`endif

endmodule

// File: tb/tb_stats_dma_latency_mc.sv
// Scoreboard bench for stats_dma_latency_mc (drop_count checked only when
// STATS_DMA_LATENCY_DROP_CNT_EN is defined).
module tb_stats_dma_latency_mc;

    localparam int CH = 2;
    localparam int TW = 8;
    localparam int LW = 16;
    localparam int SW = 4;
    localparam int CW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic [0:0]    ch;
        logic [TW-1:0] tag;
        logic [LW-1:0] len;
        logic [SW-1:0] status;
        logic [CW-1:0] lat;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*TW-1:0]  in_start_tag;
    logic [CH*LW-1:0]  in_start_len;
    logic [CH-1:0]     in_start_valid;
    logic [CH*TW-1:0]  in_finish_tag;
    logic [CH*SW-1:0]  in_finish_status;
    logic [CH-1:0]     in_finish_valid;
    logic [0:0]        out_ch;
    logic [TW-1:0]     out_tag;
    logic [LW-1:0]     out_len;
    logic [SW-1:0]     out_status;
    logic [CW-1:0]     out_latency;
    logic              out_error;
    logic              out_valid;
    logic              out_ready;
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
    logic [DW-1:0]     drop_count;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;
    logic [15:0] tcnt;

    stats_dma_latency_mc dut (
        .clk              (clk),
        .rst              (rst),
        .in_start_tag     (in_start_tag),
        .in_start_len     (in_start_len),
        .in_start_valid   (in_start_valid),
        .in_finish_tag    (in_finish_tag),
        .in_finish_status (in_finish_status),
        .in_finish_valid  (in_finish_valid),
        .out_ch           (out_ch),
        .out_tag          (out_tag),
        .out_len          (out_len),
        .out_status       (out_status),
        .out_latency      (out_latency),
        .out_error        (out_error),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Scheduling reference: cycles since reset release.
    always @(posedge clk) begin
        if (rst) tcnt <= 16'd0;
        else     tcnt <= tcnt + 16'd1;
    end

    // Monitor: compare every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_a = '{out_ch, out_tag, out_len, out_status, out_latency,
                      out_error};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got ch%0d tag%0d len%0d st%0d lat%0d err%0d, none expected",
                         out_ch, out_tag, out_len, out_status, out_latency, out_error);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL out_rec: got ch%0d tag%0d len%0d st%0d lat%0d err%0d, expected ch%0d tag%0d len%0d st%0d lat%0d err%0d",
                             mon_a.ch, mon_a.tag, mon_a.len, mon_a.status, mon_a.lat, mon_a.err,
                             mon_e.ch, mon_e.tag, mon_e.len, mon_e.status, mon_e.lat, mon_e.err);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        in_start_valid  = '0;
        in_finish_valid = '0;
    endtask

    task automatic fire();
        tick();
        clear();
    endtask

    task automatic wait_count(input logic [15:0] v);
        while (tcnt != v) tick();
    endtask

    task automatic start(input int ch, input int tag, input int len);
        in_start_tag[ch*TW +: TW] = TW'(tag);
        in_start_len[ch*LW +: LW] = LW'(len);
        in_start_valid[ch]        = 1'b1;
    endtask

    task automatic finish(input int ch, input int tag, input int st);
        in_finish_tag[ch*TW +: TW]    = TW'(tag);
        in_finish_status[ch*SW +: SW] = SW'(st);
        in_finish_valid[ch]           = 1'b1;
    endtask

    task automatic expect_out(input int ch, input int tag, input int len,
                              input int st, input int lat, input int err);
        sb.push_back('{1'(ch), TW'(tag), LW'(len), SW'(st), CW'(lat), 1'(err)});
    endtask

    initial begin
        rst              = 1'b1;
        out_ready        = 1'b1;
        in_start_tag     = '0;
        in_start_len     = '0;
        in_finish_tag    = '0;
        in_finish_status = '0;
        clear();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_latency", out_latency, 0);
        chk("rst_error", out_error, 0);
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
        chk("rst_drop_count", drop_count, 0);
`endif
        tick();
        rst = 1'b0;

        // Single match, latency 20, output two cycles after finish.
        wait_count(16'd10);
        start(0, 5, 100); fire();
        wait_count(16'd30);
        finish(0, 5, 3); expect_out(0, 5, 100, 3, 20, 0); fire();
        @(negedge clk);
        chk("first_cycle_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("second_cycle_valid", out_valid, 1);

        // Repeat finish of completed tag, then unmatched finish on ch1.
        wait_count(16'd40);
        finish(0, 5, 2); expect_out(0, 5, 0, 2, 0, 1); fire();
        wait_count(16'd44);
        finish(1, 9, 1); expect_out(1, 9, 0, 1, 0, 1); fire();

        // Round-robin under backpressure: ch0, ch1, ch0.
        wait_count(16'd60);
        start(0, 10, 1); start(1, 11, 2); fire();
        start(0, 12, 3); fire();
        wait_count(16'd65);
        out_ready = 1'b0;
        wait_count(16'd70);
        finish(0, 10, 4); finish(1, 11, 5);
        expect_out(0, 10, 1, 4, 10, 0);
        expect_out(1, 11, 2, 5, 10, 0);
        expect_out(0, 12, 3, 6, 10, 0);
        fire();
        finish(0, 12, 6); fire();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_ch", out_ch, 0);
            chk("stall_tag", out_tag, 10);
            chk("stall_latency", out_latency, 10);
            tick();
        end
        wait_count(16'd80);
        out_ready = 1'b1;

        // Drops: output reg and ch0 hold full, tags 2 and 3 dropped.
        wait_count(16'd100);
        start(0, 1, 11); fire();
        start(0, 2, 12); fire();
        start(0, 3, 13); fire();
        wait_count(16'd105);
        out_ready = 1'b0;
        wait_count(16'd108);
        finish(1, 200, 9); expect_out(1, 200, 0, 9, 0, 1); fire();
        wait_count(16'd110);
        finish(0, 1, 10); expect_out(0, 1, 11, 10, 10, 0); fire();
        finish(0, 2, 1); fire();
        finish(0, 3, 1); fire();
`ifdef STATS_DMA_LATENCY_DROP_CNT_EN
        @(negedge clk);
        chk("drop_count", drop_count, 2);
`endif
        wait_count(16'd120);
        out_ready = 1'b1;
        wait_count(16'd125);
        finish(0, 2, 7); expect_out(0, 2, 0, 7, 0, 1); fire();
        wait_count(16'd127);
        finish(0, 3, 8); expect_out(0, 3, 0, 8, 0, 1); fire();

        // Same-cycle start and finish of tag 7 on ch1.
        wait_count(16'd130);
        start(1, 7, 50); fire();
        wait_count(16'd140);
        start(1, 7, 60); finish(1, 7, 2);
        expect_out(1, 7, 50, 2, 10, 0); fire();
        wait_count(16'd150);
        finish(1, 7, 3); expect_out(1, 7, 60, 3, 10, 0); fire();

        // Restart of an in-flight tag overwrites silently.
        wait_count(16'd160);
        start(0, 30, 1); fire();
        wait_count(16'd170);
        start(0, 30, 2); fire();
        wait_count(16'd175);
        finish(0, 30, 4); expect_out(0, 30, 2, 4, 5, 0); fire();

        // Timebase wrap: 0xFFF0 -> 0x0010.
        wait_count(16'hFFF0);
        start(0, 20, 16'h1234); fire();
        wait_count(16'h0010);
        finish(0, 20, 5); expect_out(0, 20, 16'h1234, 5, 16'h0020, 0); fire();

        // Reset mid-flight forgets tag 4.
        wait_count(16'h0020);
        start(1, 4, 5); fire();
        repeat (5) tick();
        chk("sb_empty_pre_rst", sb.size(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        tick();
        finish(1, 4, 1); expect_out(1, 4, 0, 1, 0, 1); fire();
        repeat (6) tick();
        chk("sb_empty_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
